sine_lut_arbiter: RTL

Round-robin arbiter that shares the two phase ports of the dual-channel sine core among `NUM_REQ` phase requesters. Each cycle it grants up to two requesters, one per core port, and drives the winning phase words into the core. It carries requester IDs through a delay line matched to the core latency and returns each sample tagged with its requester ID. It sits between per-channel phase accumulators (NCOs, modulators) and the sine core.

---
 rtl/sine_lut_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sine_lut_arbiter.sv
// Round-robin arbiter sharing the two sine-core phase ports among NUM_REQ requesters.
// Define SINE_ARB_FIXED_PRIORITY_EN for fixed lowest-index-first priority (no rr_ptr state).
module sine_lut_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CORE_LAT = 3,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_phase,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             core_phase_a,
  output logic [31:0]             core_phase_b,
  input  logic signed [15:0]      core_out_a,
  input  logic signed [15:0]      core_out_b,
  output logic                    rsp_valid_a,
  output logic                    rsp_valid_b,
  output logic [ID_W-1:0]         rsp_id_a,
  output logic [ID_W-1:0]         rsp_id_b,
  output logic signed [15:0]      rsp_data_a,
  output logic signed [15:0]      rsp_data_b
);

  logic [ID_W-1:0] rr_ptr;
  logic            a_hit, b_hit;
  logic [ID_W-1:0] a_idx, b_idx;
  logic            grant_a, grant_b;

  logic [CORE_LAT-1:0] dl_valid_a, dl_valid_b;
  logic [ID_W-1:0]     dl_id_a [CORE_LAT];
  logic [ID_W-1:0]     dl_id_b [CORE_LAT];

  // NUM_REQ is a power of 2, so ID_W-bit index arithmetic wraps cyclically for free.
  always_comb begin
    logic [ID_W-1:0] scan_idx;
    a_hit    = 1'b0;
    a_idx    = '0;
    b_hit    = 1'b0;
    b_idx    = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr + ID_W'(k);
      if (!a_hit && req_valid[scan_idx]) begin
        a_hit = 1'b1;
        a_idx = scan_idx;
      end
    end
    for (int unsigned k = 1; k < NUM_REQ; k++) begin
      scan_idx = a_idx + ID_W'(k);
      if (a_hit && !b_hit && req_valid[scan_idx]) begin
        b_hit = 1'b1;
        b_idx = scan_idx;
      end
    end
  end

  assign grant_a = a_hit & en & rst_n;
  assign grant_b = b_hit & en & rst_n;

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[a_idx] = 1'b1;
    if (grant_b) req_ready[b_idx] = 1'b1;
  end

`ifdef SINE_ARB_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] last_idx;
  assign last_idx = grant_b ? b_idx : a_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_a) begin
      rr_ptr <= last_idx + ID_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_phase_a <= '0;
      core_phase_b <= '0;
    end else begin
      if (grant_a) core_phase_a <= req_phase[32*a_idx +: 32];
      if (grant_b) core_phase_b <= req_phase[32*b_idx +: 32];
    end
  end

  // ID/valid delay line tracks each phase word through the core so responses come back tagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_a <= '0;
      dl_valid_b <= '0;
      for (int unsigned i = 0; i < CORE_LAT; i++) begin
        dl_id_a[i] <= '0;
        dl_id_b[i] <= '0;
      end
    end else begin
      dl_valid_a[0] <= grant_a;
      dl_valid_b[0] <= grant_b;
      dl_id_a[0]    <= a_idx;
      dl_id_b[0]    <= b_idx;
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
        dl_valid_a[i] <= dl_valid_a[i-1];
        dl_valid_b[i] <= dl_valid_b[i-1];
        dl_id_a[i]    <= dl_id_a[i-1];
        dl_id_b[i]    <= dl_id_b[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      rsp_id_a    <= '0;
      rsp_id_b    <= '0;
      rsp_data_a  <= '0;
      rsp_data_b  <= '0;
    end else begin
      rsp_valid_a <= dl_valid_a[CORE_LAT-1];
      rsp_valid_b <= dl_valid_b[CORE_LAT-1];
      rsp_id_a    <= dl_id_a[CORE_LAT-1];
      rsp_id_b    <= dl_id_b[CORE_LAT-1];
      if (dl_valid_a[CORE_LAT-1]) rsp_data_a <= core_out_a;
      if (dl_valid_b[CORE_LAT-1]) rsp_data_b <= core_out_b;
    end
  end

endmodule
